// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : load/store stage with req/ack memory handshake and timeout
// Optional: MEM_FWD_EN forwards the last acked store to a matching load
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [15:0] Controll_Signal_In,
  input  logic [15:0] Read1_In,
  input  logic [15:0] AluOrMem_In,
  input  logic [3:0]  Rd_In,
  input  logic        Mem_Ack,
  input  logic [15:0] Mem_RData,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  output logic        Stall_Out,
  output logic [15:0] Controll_Signal_Out,
  output logic [15:0] WB_Data_Out,
  output logic [3:0]  Rd_Out,
  output logic        Valid_Out,
  output logic        Err_Out
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        ctrl_q;
  logic [3:0]         rd_q;
  logic               req_q, we_q, valid_q, err_q;
  logic [15:0]        addr_q, wdata_q, ctrl_out_q, wb_q;
  logic [3:0]         rd_out_q;

  logic w_mem_read, w_mem_write, w_memop, w_timeout, w_fwd_hit;
  logic [15:0] w_idle_wb;

  assign w_mem_read  = Controll_Signal_In[0];
  assign w_mem_write = Controll_Signal_In[1];
  assign w_memop     = w_mem_read | w_mem_write;
  assign w_timeout   = (cnt_q == C_TO_LAST);

`ifdef MEM_FWD_EN
  logic [15:0] ls_addr_q, ls_data_q;
  logic        ls_valid_q;

  // Only a pure load may hit; a read+write word is a store and must go out.
  assign w_fwd_hit = ls_valid_q && w_mem_read && !w_mem_write &&
                     (AluOrMem_In == ls_addr_q);
  assign w_idle_wb = (w_fwd_hit && Controll_Signal_In[3]) ? ls_data_q : AluOrMem_In;

  always_ff @(posedge clk) begin
    if (rest) begin
      ls_valid_q <= 1'b0;
      ls_addr_q  <= '0;
      ls_data_q  <= '0;
    end else if (state_q == S_ACCESS && Mem_Ack && we_q) begin
      ls_valid_q <= 1'b1;
      ls_addr_q  <= addr_q;
      ls_data_q  <= wdata_q;
    end
  end
`else
  assign w_fwd_hit = 1'b0;
  assign w_idle_wb = AluOrMem_In;
`endif

  always_comb begin
    Stall_Out = 1'b0;
    case (state_q)
      S_IDLE:   Stall_Out = w_memop && !w_fwd_hit;
      S_ACCESS: Stall_Out = !Mem_Ack && !w_timeout;
      default:  Stall_Out = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_out_q <= '0;
      wb_q       <= '0;
      rd_out_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_memop && !w_fwd_hit) begin
            req_q   <= 1'b1;
            we_q    <= w_mem_write;
            addr_q  <= AluOrMem_In;
            wdata_q <= Read1_In;
            ctrl_q  <= Controll_Signal_In;
            rd_q    <= Rd_In;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_ACCESS;
          end else begin
            ctrl_out_q <= Controll_Signal_In;
            wb_q       <= w_idle_wb;
            rd_out_q   <= Rd_In;
            valid_q    <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (Mem_Ack) begin
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            ctrl_out_q <= ctrl_q;
            rd_out_q   <= rd_q;
            wb_q       <= ctrl_q[3] ? Mem_RData : addr_q;
            state_q    <= S_IDLE;
          end else if (w_timeout) begin
            // Abandoned access retires as a bubble-like result that cannot write back.
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            valid_q    <= 1'b1;
            ctrl_out_q <= ctrl_q & ~16'h0004;
            rd_out_q   <= rd_q;
            wb_q       <= '0;
            state_q    <= S_IDLE;
          end else if (cnt_q != C_CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Mem_Req             = req_q;
  assign Mem_We              = we_q;
  assign Mem_Addr            = addr_q;
  assign Mem_WData           = wdata_q;
  assign Controll_Signal_Out = ctrl_out_q;
  assign WB_Data_Out         = wb_q;
  assign Rd_Out              = rd_out_q;
  assign Valid_Out           = valid_q;
  assign Err_Out             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed self-checking bench for mem_access_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rest;
  logic [15:0] ctrl_in, read1_in, alu_in, rdata;
  logic [3:0]  rd_in;
  logic        ack;
  logic        mem_req, mem_we, stall, valid, err;
  logic [15:0] mem_addr, mem_wdata, ctrl_out, wb_data;
  logic [3:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(15), .CNT_W(8)) u_dut (
    .clk                 (clk),
    .rest                (rest),
    .Controll_Signal_In  (ctrl_in),
    .Read1_In            (read1_in),
    .AluOrMem_In         (alu_in),
    .Rd_In               (rd_in),
    .Mem_Ack             (ack),
    .Mem_RData           (rdata),
    .Mem_Req             (mem_req),
    .Mem_We              (mem_we),
    .Mem_Addr            (mem_addr),
    .Mem_WData           (mem_wdata),
    .Stall_Out           (stall),
    .Controll_Signal_Out (ctrl_out),
    .WB_Data_Out         (wb_data),
    .Rd_Out              (rd_out),
    .Valid_Out           (valid),
    .Err_Out             (err)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] c, input logic [15:0] r1,
                       input logic [15:0] a, input logic [3:0] rd);
    ctrl_in  = c;
    read1_in = r1;
    alu_in   = a;
    rd_in    = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rest = 1'b1; ack = 1'b0; rdata = '0;
    drive(16'h0, 16'h0, 16'h0, 4'h0);
    step(); step();
    chk("rst_valid", {15'b0, valid}, 16'h0);
    chk("rst_req",   {15'b0, mem_req}, 16'h0);
    chk("rst_wb",    wb_data, 16'h0);
    chk("rst_ctrl",  ctrl_out, 16'h0);
    chk("rst_err",   {15'b0, err}, 16'h0);
    rest = 1'b0;

    // 1: ALU op
    drive(16'h0004, 16'h0, 16'h1234, 4'd5);
    chk("alu_stall", {15'b0, stall}, 16'h0);
    step();
    chk("alu_valid", {15'b0, valid}, 16'h1);
    chk("alu_wb",    wb_data, 16'h1234);
    chk("alu_rd",    {12'b0, rd_out}, 16'h5);
    chk("alu_req",   {15'b0, mem_req}, 16'h0);

    // 2: load, ack in the 4th ACCESS cycle
    drive(16'h000D, 16'h0, 16'h0040, 4'd3);
    chk("ld_stall0", {15'b0, stall}, 16'h1);
    step();
    chk("ld_req",    {15'b0, mem_req}, 16'h1);
    chk("ld_we",     {15'b0, mem_we}, 16'h0);
    chk("ld_addr",   mem_addr, 16'h0040);
    chk("ld_valid0", {15'b0, valid}, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_acc", {15'b0, stall}, 16'h1);
      step();
    end
    ack = 1'b1; rdata = 16'hBEEF; #1;
    chk("ld_stall_ack", {15'b0, stall}, 16'h0);
    step();
    ack = 1'b0;
    drive(16'h0000, 16'h0, 16'h0, 4'd0);
    chk("ld_wb",    wb_data, 16'hBEEF);
    chk("ld_rd",    {12'b0, rd_out}, 16'h3);
    chk("ld_valid", {15'b0, valid}, 16'h1);
    chk("ld_ctrl",  ctrl_out, 16'h000D);
    chk("ld_req_done", {15'b0, mem_req}, 16'h0);

    // 3: store, immediate ack
    drive(16'h0002, 16'hA5A5, 16'h0010, 4'd7);
    step();
    chk("st_we",    {15'b0, mem_we}, 16'h1);
    chk("st_wdata", mem_wdata, 16'hA5A5);
    chk("st_addr",  mem_addr, 16'h0010);
    ack = 1'b1; #1;
    chk("st_stall", {15'b0, stall}, 16'h0);
    step();
    ack = 1'b0;
    drive(16'h0000, 16'h0, 16'h0, 4'd0);
    chk("st_valid", {15'b0, valid}, 16'h1);
    chk("st_ctrl",  ctrl_out, 16'h0002);
    chk("st_wb",    wb_data, 16'h0010);

    // 4: load that never gets acked
    drive(16'h000D, 16'h0, 16'h0050, 4'd9);
    step();
    for (int i = 0; i < 14; i++) begin
      chk("to_stall", {15'b0, stall}, 16'h1);
      step();
    end
    chk("to_stall_last", {15'b0, stall}, 16'h0);
    chk("to_req_last",   {15'b0, mem_req}, 16'h1);
    step();
    drive(16'h0004, 16'h0, 16'h7777, 4'd2);
    chk("to_req",   {15'b0, mem_req}, 16'h0);
    chk("to_err",   {15'b0, err}, 16'h1);
    chk("to_valid", {15'b0, valid}, 16'h1);
    chk("to_ctrl",  ctrl_out, 16'h0009);
    chk("to_wb",    wb_data, 16'h0);
    chk("to_rd",    {12'b0, rd_out}, 16'h9);
    chk("to_stall_after", {15'b0, stall}, 16'h0);
    step();
    chk("to_alu_wb",  wb_data, 16'h7777);
    chk("to_err_sticky", {15'b0, err}, 16'h1);

    // 5: reset during ACCESS, then a late ack
    drive(16'h000D, 16'h0, 16'h0060, 4'd6);
    step(); step();
    rest = 1'b1;
    step();
    chk("rr_req",   {15'b0, mem_req}, 16'h0);
    chk("rr_err",   {15'b0, err}, 16'h0);
    chk("rr_valid", {15'b0, valid}, 16'h0);
    chk("rr_addr",  mem_addr, 16'h0);
    chk("rr_ctrl",  ctrl_out, 16'h0);
    rest = 1'b0;
    ack = 1'b1; rdata = 16'hDEAD;
    drive(16'h0008, 16'h0, 16'h0011, 4'd1);
    chk("rr_stall", {15'b0, stall}, 16'h0);
    step();
    ack = 1'b0;
    chk("rr_late_wb",  wb_data, 16'h0011);
    chk("rr_late_req", {15'b0, mem_req}, 16'h0);
    chk("rr_late_err", {15'b0, err}, 16'h0);

    // 7: ack arrives in the timeout cycle
    drive(16'h000D, 16'h0, 16'h0070, 4'd4);
    step();
    repeat (14) step();
    ack = 1'b1; rdata = 16'h1357; #1;
    step();
    ack = 1'b0;
    drive(16'h0000, 16'h0, 16'h0, 4'd0);
    chk("race_err",  {15'b0, err}, 16'h0);
    chk("race_wb",   wb_data, 16'h1357);
    chk("race_ctrl", ctrl_out, 16'h000D);

    // 8: read+write both set behaves as a store
    drive(16'h0003, 16'h0F0F, 16'h0030, 4'd8);
    step();
    chk("rw_we",    {15'b0, mem_we}, 16'h1);
    chk("rw_wdata", mem_wdata, 16'h0F0F);
    ack = 1'b1; #1;
    step();
    ack = 1'b0;
    drive(16'h0000, 16'h0, 16'h0, 4'd0);
    chk("rw_valid", {15'b0, valid}, 16'h1);

    // 6: store then load to the same address
    drive(16'h0002, 16'h5555, 16'h0020, 4'd0);
    step();
    ack = 1'b1; #1;
    step();
    ack = 1'b0;
    drive(16'h000D, 16'h0, 16'h0020, 4'd10);
`ifdef MEM_FWD_EN
    chk("fwd_stall", {15'b0, stall}, 16'h0);
    step();
    chk("fwd_req",   {15'b0, mem_req}, 16'h0);
    chk("fwd_wb",    wb_data, 16'h5555);
    chk("fwd_valid", {15'b0, valid}, 16'h1);
    chk("fwd_rd",    {12'b0, rd_out}, 16'hA);
`else
    chk("nofwd_stall", {15'b0, stall}, 16'h1);
    step();
    chk("nofwd_req", {15'b0, mem_req}, 16'h1);
    ack = 1'b1; rdata = 16'h9999; #1;
    step();
    ack = 1'b0;
    chk("nofwd_wb",  wb_data, 16'h9999);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
